wb_dbus_arbiter2: RTL and testbench

- Two-master, one-slave Wishbone arbiter that shares the SoC data-bus fabric (RAM/UART/GPIO decode) between the core dbus master (M0) and a second master (M1), such as a loader or DMA.
- Round-robin grant with bus lock for the whole `cyc` cycle.
- Registered grant.
- Watchdog timeout terminates a hung transfer with `err`, so a missing slave `ack` cannot stall the SoC.

---
 rtl/wb_dbus_arbiter2_pkg.sv | 34 +++
 rtl/wb_dbus_arbiter2_if.sv | 25 ++
 rtl/wb_dbus_arbiter2_watchdog.sv | 31 +++
 rtl/wb_dbus_arbiter2.sv | 175 +++++++++++++++++
 tb/tb_wb_dbus_arbiter2.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_dbus_arbiter2_pkg.sv
// Shared types and constants for the two-master Wishbone data-bus arbiter.
package wb_dbus_arbiter2_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GNT0 = 2'b01,
        ST_GNT1 = 2'b10,
        ST_TERM = 2'b11
    } state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Request-side payload forwarded from the granted master to the slave
    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic             cyc;
        logic             stb;
    } wb_req_t;

    // One-hot grant vector for master index m (0 -> M0, 1 -> M1)
    function automatic logic [1:0] grant_of(input logic m);
        return m ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/wb_dbus_arbiter2_if.sv
// Wishbone classic bus bundle; err is only ever raised by the arbiter toward its masters.
interface wb_dbus_arbiter2_if;
    import wb_dbus_arbiter2_pkg::*;

    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [DAT_W-1:0] dat_r;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic             cyc;
    logic             stb;
    logic             ack;
    logic             err;

    modport master (
        output adr, dat_w, we, sel, cyc, stb,
        input  dat_r, ack
    );

    modport slave (
        input  adr, dat_w, we, sel, cyc, stb,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_dbus_arbiter2_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and flags the one that would reach all-ones.
module wb_watchdog #(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_stall,
    output logic o_expire_c
);

    // Count value at which one more stalled cycle completes 2^TIMEOUT_W-1 stalls
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = ~(TIMEOUT_W'(1));

    logic [TIMEOUT_W-1:0] r_count;

    // An ack in the same cycle clears i_stall, so ack always beats expiry
    assign o_expire_c = i_stall && (r_count == CNT_LAST);

    // Stall counter, cleared on ack, on leaving a grant, or on expiry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr || o_expire_c) begin
            r_count <= '0;
        end else if (i_stall) begin
            r_count <= r_count + TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/wb_dbus_arbiter2.sv
// Two-master round-robin Wishbone arbiter with cycle lock and stall watchdog.
module wb_dbus_arbiter2
    import wb_dbus_arbiter2_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    wb_dbus_arbiter2_if.slave         wb_m0,
    wb_dbus_arbiter2_if.slave         wb_m1,
    wb_dbus_arbiter2_if.master        wb_s,
    output logic [1:0]                grant_o
);

    state_e     r_state;
    state_e     w_state_nxt;
    logic       r_last_grant;
    logic       w_last_nxt;
    logic       r_err_pending;
    logic       w_err_nxt;
    logic [1:0] r_grant;
    logic [1:0] w_grant_nxt;

    logic       w_in_gnt;
    logic       w_own_cyc;
    logic       w_other_cyc;
    logic       w_stall;
    logic       w_clr;
    logic       w_expire;

    wb_req_t    w_req_m0;
    wb_req_t    w_req_m1;
    wb_req_t    w_req;

    assign w_req_m0 = '{adr: wb_m0.adr, dat: wb_m0.dat_w, we: wb_m0.we,
                        sel: wb_m0.sel, cyc: wb_m0.cyc, stb: wb_m0.stb};
    assign w_req_m1 = '{adr: wb_m1.adr, dat: wb_m1.dat_w, we: wb_m1.we,
                        sel: wb_m1.sel, cyc: wb_m1.cyc, stb: wb_m1.stb};

    assign w_in_gnt    = (r_state == ST_GNT0) || (r_state == ST_GNT1);
    assign w_own_cyc   = r_last_grant ? wb_m1.cyc : wb_m0.cyc;
    assign w_other_cyc = r_last_grant ? wb_m0.cyc : wb_m1.cyc;
    assign w_stall     = w_in_gnt && w_req.cyc && w_req.stb && !wb_s.ack;
    assign w_clr       = !w_in_gnt || wb_s.ack;
    assign grant_o     = r_grant;

    wb_watchdog #(
        .TIMEOUT_W  (TIMEOUT_W)
    ) u_watchdog (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_i),
        .i_clr      (w_clr),
        .i_stall    (w_stall),
        .o_expire_c (w_expire)
    );

    // Next-state: round-robin on ties, lock while cyc held, release hands over directly
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last_grant;
        w_err_nxt   = 1'b0;
        w_grant_nxt = GNT_NONE;
        case (r_state)
            ST_IDLE: begin
                if (wb_m0.cyc && wb_m1.cyc) begin
                    w_state_nxt = r_last_grant ? ST_GNT0 : ST_GNT1;
                end else if (wb_m0.cyc) begin
                    w_state_nxt = ST_GNT0;
                end else if (wb_m1.cyc) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!wb_m0.cyc) begin
                    w_state_nxt = wb_m1.cyc ? ST_GNT1 : ST_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = ST_TERM;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_GNT1: begin
                if (!wb_m1.cyc) begin
                    w_state_nxt = wb_m0.cyc ? ST_GNT0 : ST_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = ST_TERM;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_TERM: begin
                if (!w_own_cyc) begin
                    if (w_other_cyc) begin
                        w_state_nxt = r_last_grant ? ST_GNT0 : ST_GNT1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_state_nxt == ST_GNT0) begin
            w_last_nxt = 1'b0;
        end else if (w_state_nxt == ST_GNT1) begin
            w_last_nxt = 1'b1;
        end

        case (w_state_nxt)
            ST_GNT0: w_grant_nxt = GNT_M0;
            ST_GNT1: w_grant_nxt = GNT_M1;
            ST_TERM: w_grant_nxt = grant_of(w_last_nxt);
            default: w_grant_nxt = GNT_NONE;
        endcase
    end

    // State, grant history, pending error and visible grant registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_err_pending <= 1'b0;
            r_grant       <= GNT_NONE;
        end else begin
            r_state       <= w_state_nxt;
            r_last_grant  <= w_last_nxt;
            r_err_pending <= w_err_nxt;
            r_grant       <= w_grant_nxt;
        end
    end

    // Request path: route the granted master to the slave; TERM and IDLE drive zeros
    always_comb begin
        w_req = '0;
        case (r_state)
            ST_GNT0: w_req = w_req_m0;
            ST_GNT1: w_req = w_req_m1;
            default: w_req = '0;
        endcase
    end

    assign wb_s.adr   = w_req.adr;
    assign wb_s.dat_w = w_req.dat;
    assign wb_s.we    = w_req.we;
    assign wb_s.sel   = w_req.sel;
    assign wb_s.cyc   = w_req.cyc;
    assign wb_s.stb   = w_req.stb;

    // Response path: only the granted master sees slave data/ack; err only in TERM
    always_comb begin
        wb_m0.dat_r = '0;
        wb_m0.ack   = 1'b0;
        wb_m0.err   = 1'b0;
        wb_m1.dat_r = '0;
        wb_m1.ack   = 1'b0;
        wb_m1.err   = 1'b0;
        case (r_state)
            ST_GNT0: begin
                wb_m0.dat_r = wb_s.dat_r;
                wb_m0.ack   = wb_s.ack;
            end
            ST_GNT1: begin
                wb_m1.dat_r = wb_s.dat_r;
                wb_m1.ack   = wb_s.ack;
            end
            ST_TERM: begin
                if (r_last_grant) begin
                    wb_m1.err = r_err_pending;
                end else begin
                    wb_m0.err = r_err_pending;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_dbus_arbiter2.sv
// Directed scoreboard bench for wb_dbus_arbiter2.
module tb_wb_dbus_arbiter2;
    import wb_dbus_arbiter2_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant;

    wb_dbus_arbiter2_if m0_bus ();
    wb_dbus_arbiter2_if m1_bus ();
    wb_dbus_arbiter2_if s_bus ();

    wb_dbus_arbiter2 #(
        .TIMEOUT_W (8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_m0    (m0_bus),
        .wb_m1    (m1_bus),
        .wb_s     (s_bus),
        .grant_o  (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        who;
        logic        is_err;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] lock_adr [3] = '{32'h0800_0000, 32'h0800_0100, 32'h0400_0000};
    logic [31:0] lock_dat [3] = '{32'hA0A0_0001, 32'hB1B1_0002, 32'hC2C2_0003};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
        end
    endtask

    task automatic expect_rsp(input logic who, input logic is_err, input logic [31:0] data);
        rsp_t r;
        r.who    = who;
        r.is_err = is_err;
        r.data   = data;
        exp_q.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_m0(input logic [31:0] adr, input logic [31:0] dat, input logic we);
        m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.we = we;
        m0_bus.sel = 4'hF; m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
    endtask

    task automatic set_m1(input logic [31:0] adr, input logic [31:0] dat, input logic we);
        m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.we = we;
        m1_bus.sel = 4'hF; m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
    endtask

    task automatic drop_m0();
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
    endtask

    task automatic drop_m1();
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
    endtask

    // Monitor: every ack/err seen by a master must match the head of the scoreboard
    always @(negedge clk) begin : monitor
        rsp_t        e;
        logic        a0, a1, who;
        a0 = m0_bus.ack || m0_bus.err;
        a1 = m1_bus.ack || m1_bus.err;
        if (a0 || a1) begin
            check("rsp_single_master", 32'({a1, a0} == 2'b11), 32'(0));
            who = a1;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: m%0d ack=%b err=%b, no response expected",
                         who, who ? m1_bus.ack : m0_bus.ack, who ? m1_bus.err : m0_bus.err);
            end else begin
                e = exp_q.pop_front();
                check("rsp_who", 32'(who), 32'(e.who));
                check("rsp_ack", 32'(who ? m1_bus.ack : m0_bus.ack), 32'(!e.is_err));
                check("rsp_err", 32'(who ? m1_bus.err : m0_bus.err), 32'(e.is_err));
                check("rsp_data", who ? m1_bus.dat_r : m0_bus.dat_r, e.data);
            end
        end
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL sim_time_limit: got timeout, expected normal completion");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0;
        m0_bus.adr = '0; m0_bus.dat_w = '0; m0_bus.we = 1'b0; m0_bus.sel = '0;
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        m1_bus.adr = '0; m1_bus.dat_w = '0; m1_bus.we = 1'b0; m1_bus.sel = '0;
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        s_bus.dat_r = '0; s_bus.ack = 1'b0; s_bus.err = 1'b0;

        // Reset state
        repeat (3) step();
        settle();
        check("reset_grant", 32'(grant), 32'(GNT_NONE));
        check("reset_s_cyc", 32'(s_bus.cyc), 32'(0));
        check("reset_s_stb", 32'(s_bus.stb), 32'(0));
        check("reset_s_adr", s_bus.adr, 32'(0));
        check("reset_m0_dat", m0_bus.dat_r, 32'(0));
        step();
        rst_n = 1'b1;

        // Single master write with one wait state
        step();
        set_m0(32'h0400_0010, 32'hDEAD_BEEF, 1'b1);
        settle();
        check("t1_latency_grant", 32'(grant), 32'(GNT_NONE));
        check("t1_latency_s_cyc", 32'(s_bus.cyc), 32'(0));
        step();
        settle();
        check("t1_grant", 32'(grant), 32'(GNT_M0));
        check("t1_s_adr", s_bus.adr, 32'h0400_0010);
        check("t1_s_dat", s_bus.dat_w, 32'hDEAD_BEEF);
        check("t1_s_we", 32'(s_bus.we), 32'(1));
        check("t1_s_sel", 32'(s_bus.sel), 32'hF);
        check("t1_s_stb", 32'(s_bus.stb), 32'(1));
        step();
        s_bus.ack = 1'b1; s_bus.dat_r = 32'h0000_0000;
        expect_rsp(1'b0, 1'b0, 32'h0000_0000);
        step();
        s_bus.ack = 1'b0; drop_m0();
        settle();
        check("t1_drop_s_cyc", 32'(s_bus.cyc), 32'(0));
        step();
        settle();
        check("t1_idle_grant", 32'(grant), 32'(GNT_NONE));

        // Tie after reset: M0 first, direct handover to M1
        step(); rst_n = 1'b0;
        step(); rst_n = 1'b1;
        step();
        set_m0(32'h0400_0020, 32'h1111_2222, 1'b1);
        set_m1(32'h0800_0040, 32'h0, 1'b0);
        step();
        settle();
        check("t2_tie_grant", 32'(grant), 32'(GNT_M0));
        check("t2_s_adr_m0", s_bus.adr, 32'h0400_0020);
        check("t2_m1_dat_zero", m1_bus.dat_r, 32'(0));
        step();
        s_bus.ack = 1'b1; s_bus.dat_r = 32'h0;
        expect_rsp(1'b0, 1'b0, 32'h0);
        step();
        s_bus.ack = 1'b0; drop_m0();
        settle();
        check("t2_hold_grant", 32'(grant), 32'(GNT_M0));
        step();
        settle();
        check("t2_handover_grant", 32'(grant), 32'(GNT_M1));
        check("t2_s_adr_m1", s_bus.adr, 32'h0800_0040);
        check("t2_s_we_m1", 32'(s_bus.we), 32'(0));
        step();
        s_bus.ack = 1'b1; s_bus.dat_r = 32'h1234_5678;
        expect_rsp(1'b1, 1'b0, 32'h1234_5678);
        step();
        s_bus.ack = 1'b0; drop_m1();
        step();
        settle();
        check("t2_idle_grant", 32'(grant), 32'(GNT_NONE));
        step();
        set_m0(32'h0400_0030, 32'h0, 1'b1);
        set_m1(32'h0800_0030, 32'h0, 1'b0);
        step();
        settle();
        check("t2_retie_grant", 32'(grant), 32'(GNT_M0));
        step();
        drop_m0(); drop_m1();
        step();
        settle();
        check("t2_retie_idle", 32'(grant), 32'(GNT_NONE));

        // Lock: M1 holds cyc across three reads while M0 keeps requesting
        step();
        set_m0(32'h0400_0044, 32'hCAFE_0000, 1'b1);
        set_m1(lock_adr[0], 32'h0, 1'b0);
        step();
        settle();
        check("t3_grant_m1", 32'(grant), 32'(GNT_M1));
        for (int i = 0; i < 3; i++) begin
            step();
            m1_bus.adr = lock_adr[i];
            s_bus.ack = 1'b1; s_bus.dat_r = lock_dat[i];
            expect_rsp(1'b1, 1'b0, lock_dat[i]);
            settle();
            check("t3_lock_grant", 32'(grant), 32'(GNT_M1));
            check("t3_lock_s_adr", s_bus.adr, lock_adr[i]);
            check("t3_lock_m0_dat", m0_bus.dat_r, 32'(0));
        end
        step();
        s_bus.ack = 1'b0; drop_m1();
        settle();
        check("t3_release_hold", 32'(grant), 32'(GNT_M1));
        step();
        settle();
        check("t3_m0_granted", 32'(grant), 32'(GNT_M0));
        check("t3_m0_s_adr", s_bus.adr, 32'h0400_0044);

        // Timeout: stb first at slave in this cycle, err 255 cycles later
        repeat (254) step();
        settle();
        check("t4_no_early_err", 32'(m0_bus.err), 32'(0));
        check("t4_s_cyc_before", 32'(s_bus.cyc), 32'(1));
        step();
        expect_rsp(1'b0, 1'b1, 32'h0);
        s_bus.ack = 1'b1; s_bus.dat_r = 32'hBAD0_BAD0;
        settle();
        check("t4_term_s_cyc", 32'(s_bus.cyc), 32'(0));
        check("t4_term_s_stb", 32'(s_bus.stb), 32'(0));
        check("t4_term_grant", 32'(grant), 32'(GNT_M0));
        step();
        settle();
        check("t4_late_ack_m0", 32'(m0_bus.ack), 32'(0));
        check("t4_err_one_cycle", 32'(m0_bus.err), 32'(0));
        step();
        s_bus.ack = 1'b0; drop_m0();
        step();
        settle();
        check("t4_idle_grant", 32'(grant), 32'(GNT_NONE));

        // Ack/timeout race: ack on the 255th stalled cycle wins
        step();
        set_m0(32'h0400_0050, 32'h5555_AAAA, 1'b1);
        step();
        settle();
        check("t5_grant", 32'(grant), 32'(GNT_M0));
        repeat (253) step();
        step();
        s_bus.ack = 1'b1; s_bus.dat_r = 32'h0000_00A5;
        expect_rsp(1'b0, 1'b0, 32'h0000_00A5);
        settle();
        check("t5_race_no_err", 32'(m0_bus.err), 32'(0));
        step();
        s_bus.ack = 1'b0;
        settle();
        check("t5_after_no_err", 32'(m0_bus.err), 32'(0));
        check("t5_still_granted", 32'(grant), 32'(GNT_M0));
        step();
        drop_m0();
        step();
        settle();
        check("t5_idle_grant", 32'(grant), 32'(GNT_NONE));

        // Asynchronous reset during an M1 write
        step();
        set_m1(32'h0400_0060, 32'h7777_8888, 1'b1);
        step();
        settle();
        check("t6_grant_m1", 32'(grant), 32'(GNT_M1));
        check("t6_s_cyc_on", 32'(s_bus.cyc), 32'(1));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_grant", 32'(grant), 32'(GNT_NONE));
        check("t6_async_s_cyc", 32'(s_bus.cyc), 32'(0));
        check("t6_async_s_stb", 32'(s_bus.stb), 32'(0));
        check("t6_async_s_adr", s_bus.adr, 32'(0));
        check("t6_async_s_dat", s_bus.dat_w, 32'(0));
        check("t6_async_s_we", 32'(s_bus.we), 32'(0));
        step();
        drop_m1();
        step();
        rst_n = 1'b1;
        step();
        set_m0(32'h0400_0070, 32'h0, 1'b0);
        set_m1(32'h0800_0070, 32'h0, 1'b0);
        step();
        settle();
        check("t6_post_reset_tie", 32'(grant), 32'(GNT_M0));
        step();
        drop_m0(); drop_m1();
        step();
        step();

        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
